// File: rtl/write_data_checker.sv
// Write-path checker: seeds and advances the pattern generator, buffers expected words in a
// 2-entry FIFO and compares them against received host words, reporting counts and first mismatch.
module write_data_checker #(
  parameter int DATA_WIDTH    = 64,
  parameter int LEN_WIDTH     = 32,
  parameter int ERR_CNT_WIDTH = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     start_i,
  input  logic                     abort_i,
  input  logic [LEN_WIDTH-1:0]     transfer_len_i,
  output logic                     gen_init_o,
  output logic                     enable_gener_o,
  input  logic [DATA_WIDTH-1:0]    expected_data_i,
  input  logic                     expected_valid_i,
  input  logic [DATA_WIDTH-1:0]    rx_data_i,
  input  logic                     rx_valid_i,
  output logic                     rx_ready_o,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     pass_o,
  output logic [LEN_WIDTH-1:0]     word_count_o,
  output logic [ERR_CNT_WIDTH-1:0] err_count_o,
  output logic [LEN_WIDTH-1:0]     first_err_index_o,
  output logic [DATA_WIDTH-1:0]    first_err_expected_o,
  output logic [DATA_WIDTH-1:0]    first_err_received_o,
  output logic                     protocol_err_o
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_INIT = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]               state_q, state_d;
  logic [LEN_WIDTH-1:0]     len_q, len_d, req_cnt_q, req_cnt_d;
  logic [LEN_WIDTH-1:0]     word_cnt_q, word_cnt_d, fe_idx_q, fe_idx_d;
  logic [ERR_CNT_WIDTH-1:0] err_cnt_q, err_cnt_d;
  logic [DATA_WIDTH-1:0]    fe_exp_q, fe_exp_d, fe_rcv_q, fe_rcv_d;
  logic                     perr_q, perr_d, inflight_q, inflight_d;
  logic                     rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [1:0]               occ_q, occ_d;
  logic [DATA_WIDTH-1:0]    buf_q [2];

  logic                     run, pop, push_req, push, mismatch, enable;
  logic [DATA_WIDTH-1:0]    head;

  assign run        = (state_q == S_RUN);
  assign head       = buf_q[rd_ptr_q];
  assign rx_ready_o = run && (occ_q != 2'd0) && (word_cnt_q != len_q);
  assign pop        = rx_ready_o && rx_valid_i;
  assign mismatch   = pop && (head != rx_data_i);
  // Requests in flight count against buffer space so a returning word always has a slot.
  assign enable     = run && (req_cnt_q < len_q) &&
                      (({1'b0, occ_q} + {2'b00, inflight_q}) < (3'd2 + {2'b00, pop}));
  assign push_req   = run && expected_valid_i;
  assign push       = push_req && ((occ_q != 2'd2) || pop);

  assign gen_init_o           = (state_q == S_INIT);
  assign enable_gener_o       = enable;
  assign busy_o               = (state_q == S_INIT) || run;
  assign done_o               = (state_q == S_DONE);
  assign pass_o               = (state_q == S_DONE) && (err_cnt_q == '0);
  assign word_count_o         = word_cnt_q;
  assign err_count_o          = err_cnt_q;
  assign first_err_index_o    = fe_idx_q;
  assign first_err_expected_o = fe_exp_q;
  assign first_err_received_o = fe_rcv_q;
  assign protocol_err_o       = perr_q;

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    req_cnt_d  = req_cnt_q;
    word_cnt_d = word_cnt_q;
    err_cnt_d  = err_cnt_q;
    fe_idx_d   = fe_idx_q;
    fe_exp_d   = fe_exp_q;
    fe_rcv_d   = fe_rcv_q;
    inflight_d = enable;
    rd_ptr_d   = rd_ptr_q ^ pop;
    wr_ptr_d   = wr_ptr_q ^ push;
    occ_d      = occ_q + {1'b0, push} - {1'b0, pop};
    perr_d     = perr_q | (push_req & ~push);
    if (enable) req_cnt_d = req_cnt_q + LEN_WIDTH'(1);
    if (pop) word_cnt_d = word_cnt_q + LEN_WIDTH'(1);
    if (mismatch) begin
      if (err_cnt_q != '1) err_cnt_d = err_cnt_q + ERR_CNT_WIDTH'(1);
      if (err_cnt_q == '0) begin
        fe_idx_d = word_cnt_q;
        fe_exp_d = head;
        fe_rcv_d = rx_data_i;
      end
    end
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          len_d = transfer_len_i;
          if (transfer_len_i == '0) begin
            state_d    = S_DONE;
            word_cnt_d = '0;
            err_cnt_d  = '0;
            fe_idx_d   = '0;
            fe_exp_d   = '0;
            fe_rcv_d   = '0;
          end else begin
            state_d = S_INIT;
          end
        end
      end
      S_INIT: begin
        req_cnt_d  = '0;
        word_cnt_d = '0;
        err_cnt_d  = '0;
        fe_idx_d   = '0;
        fe_exp_d   = '0;
        fe_rcv_d   = '0;
        rd_ptr_d   = 1'b0;
        wr_ptr_d   = 1'b0;
        occ_d      = 2'd0;
        state_d    = (len_q == '0) ? S_DONE : S_RUN;
      end
      S_RUN: begin
        if (pop && (word_cnt_d == len_q)) state_d = S_DONE;
      end
      S_DONE: begin
        if (start_i) begin
          len_d   = transfer_len_i;
          state_d = S_INIT;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (abort_i) state_d = S_IDLE;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= S_IDLE;
      len_q      <= '0;
      req_cnt_q  <= '0;
      word_cnt_q <= '0;
      err_cnt_q  <= '0;
      fe_idx_q   <= '0;
      fe_exp_q   <= '0;
      fe_rcv_q   <= '0;
      perr_q     <= 1'b0;
      inflight_q <= 1'b0;
      rd_ptr_q   <= 1'b0;
      wr_ptr_q   <= 1'b0;
      occ_q      <= 2'd0;
      buf_q[0]   <= '0;
      buf_q[1]   <= '0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      req_cnt_q  <= req_cnt_d;
      word_cnt_q <= word_cnt_d;
      err_cnt_q  <= err_cnt_d;
      fe_idx_q   <= fe_idx_d;
      fe_exp_q   <= fe_exp_d;
      fe_rcv_q   <= fe_rcv_d;
      perr_q     <= perr_d;
      inflight_q <= inflight_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      occ_q      <= occ_d;
      if (push) buf_q[wr_ptr_q] <= expected_data_i;
    end
  end

endmodule
